marc_processor: RTL and testbench
=================================

Name: marc_processor

Overview:
- 16-bit multi-cycle mini-ARC CPU core ("mARC"): eight 16-bit registers, 16-bit fixed-length instructions, N/Z/V/C flags.
- Sits between system clock/reset and a single unified instruction/data memory port.
- Every instruction takes exactly 5 clock cycles.
- busA carries the address, busB carries store data, dataIn returns instruction or load data.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- dataIn  input  16  instruction/load data from memory; combinationally valid in FETCH and MEMORY cycles.
- busA  output  16  memory address: PC except during MEMORY cycle of ld/st, where it is r[rs1].
- busB  output  16  store data r[rd] during MEMORY cycle of st; otherwise last operand-B latch.
- rw  output  1  1 = memory write, high only in MEMORY cycle of st.

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC; r0..r7=0; flags=0; IR=0; state=FETCH.
  - busA=RESET_PC, busB=0, rw=0.
- r0 reads as 0; writes to r0 are discarded.
- State cycle FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH, one state per clock.
  - FETCH: busA=PC; IR<=dataIn at edge.
  - DECODE: latch A=r[rs1], B=r[rs2] (jmp: A=r[IR[2:0]]; st: B=r[rd]).
  - EXECUTE: ALU result and flags latched; link value PC+2 and branch target latched.
  - MEMORY:
    - ld/st: busA=A.
    - st: busB=B, rw=1.
    - ld: result<=dataIn.
    - PC<=next PC at end of MEMORY for all instructions.
  - WRITEBACK: register write; busA already shows the new PC.
- Encoding:
  - Call: IR[15]=1. PC<=PC+(sext(IR[14:0])<<1), 16-bit wraparound; r7<=PC_call+2.
  - IR[15]=0 fields: op=IR[14:11], rd=IR[10:8], rs1=IR[7:5], rs2=IR[4:2].
- Opcodes:
  - 0000 add: rd<=rs1+rs2.
  - 0001 or: rd<=rs1|rs2; mov is or rd,rs1,r0.
  - 0010 addcc.
  - 0011 andcc.
  - 0100 subcc: rd<=rs1-rs2.
  - 0101 orcc.
  - 0110 ld: rd<=mem[r[rs1]].
  - 0111 st: mem[r[rs1]]<=r[rd].
  - 1001 branch, see below.
  - 1010 setlow: rd<={8'h00,IR[7:0]}.
  - 1011 sethi: rd<={IR[7:0],8'h00}.
  - Others: nop, PC+2.
- cc ops set flags:
  - N=res[15]; Z=(res==0).
  - V=signed overflow (0 for logic ops).
  - C=carry out for add; borrow for sub; 0 for logic ops.
- Branch (op 1001), cond=IR[10:8]:
  - 000 jmp: PC<=r[IR[2:0]].
  - 001 ba; 010 be (Z); 011 bne (!Z); 100 bneg (N).
  - 101 ble (Z|(N^V)); 110 bl (N^V); 111 bcs (C).
  - Taken: PC<=PC_branch+sext(IR[7:0]) (byte offset). Not taken: PC+2.
- Non-branch, non-call instructions: PC<=PC+2.
- Flags change only on cc ops.
- Reset mid-instruction aborts it: no partial register/memory write; rw drops to 0 immediately.

Decomposition:
- Package marc_pkg: opcode constants, condition codes, state enum (FETCH..WRITEBACK), field-slice localparams.
- One sub-module, marc_alu: combinational add/sub/and/or with N/Z/V/C out.
- Register file and FSM stay in the top.

Test Plan:
- Boot: reset pulse, dataIn=16'h8200 (call) -> after 5 cycles busA=16'h0400, rw=0 throughout.
- setlow/sethi: 16'h5140 then 16'h5A01 -> r1=0x0040, r2=0x0100 (checked via a following st: busB value).
- Call/return:
  - call at 0x0404 with disp field 0x7600 -> busA=0xF004.
  - Later jmp %r7 (16'h4807) -> busA=0x0406.
- Conditional branch:
  - subcc r0<-r1-r2 (64-256), then ble +6 (16'h4D06) at 0xF006 -> busA=0xF00C.
  - Swapping operand values -> not taken, busA=0xF008.
  - ba +4 (16'h4904) at 0xF00A -> busA=0xF00E.
- Store/load:
  - r6=0x0800 (16'h5E08), r3=0x0100, st (16'h3BC0) -> MEMORY cycle busA=0x0800, busB=0x0100, rw=1; rw=0 in all other cycles.
  - ld returns dataIn into rd.
- Reset asserted during a st MEMORY cycle -> rw=0 and busA=0x0000 immediately; execution restarts with FETCH at 0x0000.

Source files
------------

// File: rtl/marc_pkg.sv
// Shared constants and types for the mARC 16-bit multi-cycle core.
// Covers the opcode map, branch conditions, FSM states and instruction field positions.
package marc_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH     = 3'd0;
  localparam state_t ST_DECODE    = 3'd1;
  localparam state_t ST_EXECUTE   = 3'd2;
  localparam state_t ST_MEMORY    = 3'd3;
  localparam state_t ST_WRITEBACK = 3'd4;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADDCC  = 4'b0010;
  localparam logic [3:0] OP_ANDCC  = 4'b0011;
  localparam logic [3:0] OP_SUBCC  = 4'b0100;
  localparam logic [3:0] OP_ORCC   = 4'b0101;
  localparam logic [3:0] OP_LD     = 4'b0110;
  localparam logic [3:0] OP_ST     = 4'b0111;
  localparam logic [3:0] OP_BR     = 4'b1001;
  localparam logic [3:0] OP_SETLOW = 4'b1010;
  localparam logic [3:0] OP_SETHI  = 4'b1011;

  localparam logic [2:0] CC_JMP  = 3'b000;
  localparam logic [2:0] CC_BA   = 3'b001;
  localparam logic [2:0] CC_BE   = 3'b010;
  localparam logic [2:0] CC_BNE  = 3'b011;
  localparam logic [2:0] CC_BNEG = 3'b100;
  localparam logic [2:0] CC_BLE  = 3'b101;
  localparam logic [2:0] CC_BL   = 3'b110;
  localparam logic [2:0] CC_BCS  = 3'b111;

  localparam int CALL_BIT = 15;
  localparam int OP_MSB   = 14;
  localparam int OP_LSB   = 11;
  localparam int RD_MSB   = 10;
  localparam int RD_LSB   = 8;
  localparam int RS1_MSB  = 7;
  localparam int RS1_LSB  = 5;
  localparam int RS2_MSB  = 4;
  localparam int RS2_LSB  = 2;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  function automatic logic op_writes_rd(input logic [3:0] op);
    return (op inside {OP_ADD, OP_OR, OP_ADDCC, OP_ANDCC, OP_SUBCC, OP_ORCC,
                       OP_LD, OP_SETLOW, OP_SETHI});
  endfunction

  function automatic logic op_is_cc(input logic [3:0] op);
    return (op inside {OP_ADDCC, OP_ANDCC, OP_SUBCC, OP_ORCC});
  endfunction

endpackage

// File: rtl/marc_alu.sv
// Combinational mARC ALU: add, subtract, and, or with N/Z/V/C.
// Subtraction reuses the adder as a + ~b + 1; C then reports borrow.
module marc_alu
  import marc_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  alu_op_e     i_op,
  output logic [15:0] o_res,
  output flags_t      o_flags
);

  logic        w_is_sub;
  logic [15:0] w_b_eff;
  logic [16:0] w_sum;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_is_sub = (i_op == ALU_SUB);
    w_b_eff  = w_is_sub ? ~i_b : i_b;
    w_sum    = {1'b0, i_a} + {1'b0, w_b_eff} + {16'd0, w_is_sub};
    o_res    = w_sum[15:0];
    o_flags  = '0;
    case (i_op)
      ALU_ADD, ALU_SUB: begin
        o_res     = w_sum[15:0];
        o_flags.v = (i_a[15] == w_b_eff[15]) && (w_sum[15] != i_a[15]);
        o_flags.c = w_is_sub ? ~w_sum[16] : w_sum[16];
      end
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      default: o_res = i_a | i_b;
    endcase
    o_flags.n = o_res[15];
    o_flags.z = (o_res == 16'd0);
  end

endmodule

// File: rtl/marc_processor.sv
// mARC core: 8x16 register file, five-state FETCH..WRITEBACK sequencer, single memory port.
// Every instruction spends exactly one clock in each state.
module marc_processor
  import marc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dataIn,
  output logic [15:0] busA,
  output logic [15:0] busB,
  output logic        rw
);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_res;
  logic [15:0] r_link;
  logic [15:0] r_npc;
  flags_t      r_flags;
  logic [15:0] r_regs [8];

  logic        w_is_call;
  logic [3:0]  w_op;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic        w_is_br;
  logic        w_is_jmp;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_taken;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_next_pc;
  logic [15:0] w_exec_res;
  alu_op_e     w_alu_op;
  logic [15:0] w_alu_res;
  flags_t      w_alu_flags;

  always_comb begin
    w_is_call  = r_ir[CALL_BIT];
    w_op       = r_ir[OP_MSB:OP_LSB];
    w_rd       = r_ir[RD_MSB:RD_LSB];
    w_rs1      = r_ir[RS1_MSB:RS1_LSB];
    w_rs2      = r_ir[RS2_MSB:RS2_LSB];
    w_is_br    = !w_is_call && (w_op == OP_BR);
    w_is_jmp   = w_is_br && (w_rd == CC_JMP);
    w_is_ld    = !w_is_call && (w_op == OP_LD);
    w_is_st    = !w_is_call && (w_op == OP_ST);
    w_pc_plus2 = r_pc + 16'd2;
  end

  always_comb begin
    w_alu_op = ALU_OR;
    case (w_op)
      OP_ADD, OP_ADDCC: w_alu_op = ALU_ADD;
      OP_SUBCC:         w_alu_op = ALU_SUB;
      OP_ANDCC:         w_alu_op = ALU_AND;
      default:          w_alu_op = ALU_OR;
    endcase
  end

  marc_alu u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (w_alu_op),
    .o_res   (w_alu_res),
    .o_flags (w_alu_flags)
  );

  always_comb begin
    w_taken = 1'b0;
    case (w_rd)
      CC_BA:   w_taken = 1'b1;
      CC_BE:   w_taken = r_flags.z;
      CC_BNE:  w_taken = !r_flags.z;
      CC_BNEG: w_taken = r_flags.n;
      CC_BLE:  w_taken = r_flags.z | (r_flags.n ^ r_flags.v);
      CC_BL:   w_taken = r_flags.n ^ r_flags.v;
      CC_BCS:  w_taken = r_flags.c;
      default: w_taken = 1'b0;
    endcase
  end

  // Call displacement is a word offset: {IR[14:0],0} is sext(IR[14:0])<<1 truncated to 16 bits.
  always_comb begin
    w_next_pc = w_pc_plus2;
    if (w_is_call) begin
      w_next_pc = r_pc + {r_ir[14:0], 1'b0};
    end else if (w_is_jmp) begin
      w_next_pc = r_a;
    end else if (w_is_br && w_taken) begin
      w_next_pc = r_pc + {{8{r_ir[7]}}, r_ir[7:0]};
    end
  end

  always_comb begin
    w_exec_res = w_alu_res;
    case (w_op)
      OP_SETLOW: w_exec_res = {8'h00, r_ir[7:0]};
      OP_SETHI:  w_exec_res = {r_ir[7:0], 8'h00};
      default:   w_exec_res = w_alu_res;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_link  <= '0;
      r_npc   <= '0;
      r_flags <= '0;
      // NOTE: the register file is only eight words and must read zero after reset, so it is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= dataIn;
          r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_a     <= w_is_jmp ? r_regs[r_ir[2:0]] : r_regs[w_rs1];
          r_b     <= w_is_st ? r_regs[w_rd] : r_regs[w_rs2];
          r_state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          r_res  <= w_exec_res;
          r_link <= w_pc_plus2;
          r_npc  <= w_next_pc;
          if (!w_is_call && op_is_cc(w_op)) r_flags <= w_alu_flags;
          r_state <= ST_MEMORY;
        end
        ST_MEMORY: begin
          if (w_is_ld) r_res <= dataIn;
          r_pc    <= r_npc;
          r_state <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          if (w_is_call) begin
            r_regs[7] <= r_link;
          end else if (op_writes_rd(w_op) && (w_rd != 3'd0)) begin
            r_regs[w_rd] <= r_res;
          end
          r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    busA = r_pc;
    if ((r_state == ST_MEMORY) && (w_is_ld || w_is_st)) busA = r_a;
    busB = r_b;
    rw   = (r_state == ST_MEMORY) && w_is_st;
  end

endmodule

// File: tb/tb_marc_processor.sv
// Self-checking bench for marc_processor: directed boot/call/branch/ld/st/reset steps,
// then randomized programs checked against an architectural model of the ISA.
module tb_marc_processor;

  logic        clk;
  logic        reset;
  logic [15:0] dataIn;
  logic [15:0] busA;
  logic [15:0] busB;
  logic        rw;

  int checks = 0;
  int errors = 0;

  // Architectural model state.
  logic [15:0] m_pc;
  logic [15:0] m_r [8];
  bit          m_n, m_z, m_v, m_c;

  marc_processor #(.RESET_PC(16'h0000)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataIn (dataIn),
    .busA   (busA),
    .busB   (busB),
    .rw     (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input int rd, input int rs1, input int rs2);
    return {1'b0, op, 3'(rd), 3'(rs1), 3'(rs2), 2'b00};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input int rd, input logic [7:0] imm);
    return {1'b0, op, 3'(rd), imm};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_n = 0; m_z = 0; m_v = 0; m_c = 0;
  endtask

  // Entered at the falling edge of a FETCH cycle; returns at the falling edge of the next FETCH.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] ld_val, input bit abort);
    bit          call, is_ld, is_st, wr, cc, taken, n, z, v, c;
    logic [3:0]  op;
    int          rd, rs1, rs2, s, sa, sb;
    logic [15:0] a, b, nxt, wval, st_data;
    call = ins[15];
    op   = ins[14:11];
    rd   = int'(ins[10:8]);
    rs1  = int'(ins[7:5]);
    rs2  = int'(ins[4:2]);
    a    = m_r[rs1];
    b    = m_r[rs2];
    st_data = m_r[rd];
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    nxt  = m_pc + 16'd2;
    wr = 0; cc = 0; taken = 0; v = 0; c = 0; wval = 16'h0000;
    is_ld = !call && (op == 4'd6);
    is_st = !call && (op == 4'd7);
    if (call) begin
      nxt  = m_pc + {ins[14:0], 1'b0};
      wr   = 1; rd = 7; wval = m_pc + 16'd2;
    end else begin
      case (op)
        4'd0: begin wval = a + b; wr = 1; end
        4'd1: begin wval = a | b; wr = 1; end
        4'd2: begin
          s = int'(a) + int'(b); wval = 16'(s); c = (s > 65535);
          v = (sa + sb > 32767) || (sa + sb < -32768); cc = 1; wr = 1;
        end
        4'd3: begin wval = a & b; cc = 1; wr = 1; end
        4'd4: begin
          s = int'(a) - int'(b); wval = 16'(s); c = (a < b);
          v = (sa - sb > 32767) || (sa - sb < -32768); cc = 1; wr = 1;
        end
        4'd5: begin wval = a | b; cc = 1; wr = 1; end
        4'd6: begin wval = ld_val; wr = 1; end
        4'd9: begin
          case (ins[10:8])
            3'd0: nxt = m_r[ins[2:0]];
            3'd1: taken = 1;
            3'd2: taken = m_z;
            3'd3: taken = !m_z;
            3'd4: taken = m_n;
            3'd5: taken = m_z || (m_n != m_v);
            3'd6: taken = (m_n != m_v);
            default: taken = m_c;
          endcase
          if (taken) nxt = m_pc + 16'($signed(ins[7:0]));
        end
        4'd10: begin wval = {8'h00, ins[7:0]}; wr = 1; end
        4'd11: begin wval = {ins[7:0], 8'h00}; wr = 1; end
        default: ;
      endcase
    end
    n = wval[15];
    z = (wval == 16'h0000);

    check("fetch_busA", busA, m_pc);
    check("fetch_rw", {15'd0, rw}, 16'd0);
    dataIn = ins;
    @(negedge clk);
    dataIn = 16'($urandom);
    check("decode_busA", busA, m_pc);
    check("decode_rw", {15'd0, rw}, 16'd0);
    @(negedge clk);
    check("execute_busA", busA, m_pc);
    check("execute_rw", {15'd0, rw}, 16'd0);
    @(negedge clk);
    check("memory_busA", busA, (is_ld || is_st) ? a : m_pc);
    check("memory_rw", {15'd0, rw}, {15'd0, is_st});
    if (is_st) check("memory_busB", busB, st_data);
    if (is_ld) dataIn = ld_val;
    if (abort) begin
      #2 reset = 1'b0;
      #1;
      check("abort_rw", {15'd0, rw}, 16'd0);
      check("abort_busA", busA, 16'h0000);
      check("abort_busB", busB, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
    end else begin
      @(negedge clk);
      dataIn = 16'($urandom);
      check("wb_busA", busA, nxt);
      check("wb_rw", {15'd0, rw}, 16'd0);
      m_pc = nxt;
      if (wr && rd != 0) m_r[rd] = wval;
      if (cc) begin m_n = n; m_z = z; m_v = v; m_c = c; end
      @(negedge clk);
    end
  endtask

  task automatic load_reg(input int rd, input logic [15:0] val);
    run_instr(enc_i(4'b1011, rd, val[15:8]), 16'h0, 0);
    run_instr(enc_i(4'b1010, 6, val[7:0]), 16'h0, 0);
    run_instr(enc_r(4'b0001, rd, rd, 6), 16'h0, 0);
  endtask

  initial begin
    int          ra, rb, rd, k;
    logic [15:0] val;
    logic [7:0]  off;
    model_reset();
    reset  = 1'b0;
    dataIn = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_busA", busA, 16'h0000);
    check("reset_busB", busB, 16'h0000);
    check("reset_rw", {15'd0, rw}, 16'd0);
    reset = 1'b1;

    // Boot call, set registers, call far away.
    run_instr(16'h8200, 16'h0, 0);
    check("boot_pc", busA, 16'h0400);
    run_instr(16'h5140, 16'h0, 0);
    run_instr(16'h5A01, 16'h0, 0);
    run_instr(16'hF600, 16'h0, 0);
    check("call_pc", busA, 16'hF004);
    // subcc r0 <- r1 - r2, ble taken.
    run_instr(16'h2028, 16'h0, 0);
    run_instr(16'h4D06, 16'h0, 0);
    check("ble_taken_pc", busA, 16'hF00C);
    run_instr(16'h3900, 16'h0, 0);
    run_instr(16'h3A00, 16'h0, 0);
    run_instr(16'h4807, 16'h0, 0);
    check("jmp_r7_pc", busA, 16'h0406);
    run_instr(16'hF5FF, 16'h0, 0);
    check("call2_pc", busA, 16'hF004);
    run_instr(16'h2044, 16'h0, 0);
    run_instr(16'h4D06, 16'h0, 0);
    check("ble_not_taken_pc", busA, 16'hF008);
    run_instr(16'h4000, 16'h0, 0);
    run_instr(16'h4904, 16'h0, 0);
    check("ba_pc", busA, 16'hF00E);
    // Store r3 to [r6], then load and store back.
    run_instr(16'h5E08, 16'h0, 0);
    run_instr(16'h5B01, 16'h0, 0);
    run_instr(16'h3BC0, 16'h0, 0);
    run_instr(16'h34C0, 16'hBEEF, 0);
    run_instr(16'h3CC0, 16'h0, 0);

    // Randomized programs: random operands, ALU op, store of result, branch, load.
    for (int it = 0; it < 40; it++) begin
      ra = $urandom_range(1, 5);
      rb = $urandom_range(1, 5);
      rd = $urandom_range(0, 7);
      val = 16'($urandom);
      if (it % 4 == 0) val = 16'h8000 + 16'($urandom_range(0, 3));
      load_reg(ra, val);
      load_reg(rb, 16'($urandom));
      k = $urandom_range(0, 5);
      run_instr(enc_r(4'(k), rd, ra, rb), 16'h0, 0);
      run_instr(enc_r(4'b0111, rd, 0, 0), 16'h0, 0);
      off = 8'($urandom) & 8'hFE;
      run_instr({1'b0, 4'b1001, 3'($urandom_range(1, 7)), off}, 16'h0, 0);
      if (it % 3 == 0) begin
        run_instr(enc_r(4'b0110, rd, ra, 0), 16'($urandom), 0);
        run_instr(enc_r(4'b0111, rd, rb, 0), 16'h0, 0);
      end
    end

    // Reset in the MEMORY cycle of a store aborts it and restarts at 0.
    run_instr(16'h5E08, 16'h0, 0);
    run_instr(16'h3BC0, 16'h0, 1);
    check("restart_pc", busA, 16'h0000);
    run_instr(16'h5112, 16'h0, 0);
    run_instr(16'h3900, 16'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
